// File: rtl/xnor_window_sched_if.sv
// Upstream activation/weight bit-pair stream (valid/ready) into the window scheduler.
interface xnor_window_sched_if;
  logic in_valid;
  logic in_ready;
  logic in_a;
  logic in_w;

  modport master (output in_valid, output in_a, output in_w, input in_ready);
  modport slave  (input in_valid, input in_a, input in_w, output in_ready);
endinterface

// File: rtl/xnor_window_sched.sv
// xnor_window_sched: feeds serial a/w into the registered wide XNOR stage and
// flags the cycle in which the datapath's x register holds a full WIDE-bit window.
// Optional feature: define XNOR_SCHED_BUBBLE_CNT_EN to add the bubble_cnt output.
module xnor_window_sched #(
  parameter int unsigned WIDE  = 72,
  parameter int unsigned LEN_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  job_len,
  output logic              busy,
  xnor_window_sched_if.slave up,
  output logic              a,
  output logic              w,
  output logic              x_valid,
  output logic [LEN_W-1:0]  win_idx,
  output logic              done
`ifdef XNOR_SCHED_BUBBLE_CNT_EN
  ,
  output logic [LEN_W-1:0]  bubble_cnt
`endif
);

  localparam int unsigned RUN_W = $clog2(WIDE + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       state, state_n;
  logic [LEN_W-1:0] rem, rem_n;
  logic [RUN_W-1:0] run, run_n;
  logic [LEN_W-1:0] widx, widx_n;
  logic             drain_2nd, drain_2nd_n;
  logic             win_flag;
  logic             in_ready_c;
  logic             flag_d1;
  logic [LEN_W-1:0] idx_d1;

  // State and job counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      rem       <= '0;
      run       <= '0;
      widx      <= '0;
      drain_2nd <= 1'b0;
    end else begin
      state     <= state_n;
      rem       <= rem_n;
      run       <= run_n;
      widx      <= widx_n;
      drain_2nd <= drain_2nd_n;
    end
  end

  // Next-state, acceptance, a/w drive and window-complete detection.
  always_comb begin
    state_n     = state;
    rem_n       = rem;
    run_n       = run;
    widx_n      = widx;
    drain_2nd_n = drain_2nd;
    win_flag    = 1'b0;
    in_ready_c  = 1'b0;
    a           = 1'b0;
    w           = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          drain_2nd_n = 1'b0;
          if (job_len != '0) begin
            rem_n   = job_len;
            run_n   = '0;
            widx_n  = '0;
            state_n = S_LOAD;
          end else begin
            state_n = S_DRAIN;
          end
        end
      end
      S_LOAD: begin
        in_ready_c = 1'b1;
        if (up.in_valid) begin
          a     = up.in_a;
          w     = up.in_w;
          rem_n = rem - LEN_W'(1);
          run_n = (run == RUN_W'(WIDE)) ? run : run + RUN_W'(1);
          win_flag = (run_n == RUN_W'(WIDE));
          if (win_flag) widx_n = widx + LEN_W'(1);
          if (rem == LEN_W'(1)) begin
            state_n     = S_DRAIN;
            drain_2nd_n = 1'b0;
          end
        end else begin
          // Datapath shifts a zero pair regardless, so the window restarts.
          run_n = '0;
        end
      end
      S_DRAIN: begin
        if (drain_2nd) state_n = S_IDLE;
        else drain_2nd_n = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Two-stage delay line matching a/w_reg -> x latency of the datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag_d1 <= 1'b0;
      x_valid <= 1'b0;
      idx_d1  <= '0;
      win_idx <= '0;
    end else begin
      flag_d1 <= win_flag;
      x_valid <= flag_d1;
      if (win_flag) idx_d1  <= widx;
      if (flag_d1)  win_idx <= idx_d1;
    end
  end

  assign up.in_ready = in_ready_c;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DRAIN) && drain_2nd;

`ifdef XNOR_SCHED_BUBBLE_CNT_EN
  // Saturating count of LOAD cycles without an upstream bit pair.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      bubble_cnt <= '0;
    end else if (state == S_LOAD && !up.in_valid && bubble_cnt != '1) begin
      bubble_cnt <= bubble_cnt + LEN_W'(1);
    end
  end
`endif

endmodule
